// File: rtl/fpu_spi_sched.sv
// SCLK-domain SPI command scheduler for the FPU core: deserializes 66-bit
// command frames into a FIFO and returns buffered core results on MISO.
module fpu_spi_sched #(
   parameter int CMD_DEPTH = 4,
   parameter int RES_DEPTH = 2
) (
   input  logic                       SCLK,
   input  logic                       rst,
   input  logic                       cs_n,
   input  logic                       mosi,
   output logic                       miso,
   output logic                       cmd_valid,
   output logic [1:0]                 cmd_op,
   output logic [31:0]                cmd_a,
   output logic [31:0]                cmd_b,
   input  logic                       cmd_ready,
   input  logic                       res_valid,
   input  logic [31:0]                res_data,
   input  logic                       res_err,
   output logic                       res_ready,
   output logic [$clog2(CMD_DEPTH):0] cmd_count,
   output logic                       overflow
);
   localparam int CW = $clog2(CMD_DEPTH);
   localparam int RW = $clog2(RES_DEPTH);
   localparam logic [CW:0] CMD_FULL  = (CW+1)'(CMD_DEPTH);
   localparam logic [RW:0] RES_FULL  = (RW+1)'(RES_DEPTH);
   localparam logic [6:0]  LAST_BIT  = 7'd65;
   localparam logic [6:0]  RESP_LAST = 7'd34;
   localparam logic [6:0]  RESP_LEN  = 7'd35;

   logic [6:0]    bit_cnt_r;
   logic [64:0]   rx_shift_r;

   logic [65:0]   cmd_mem_r [CMD_DEPTH];
   logic [CW-1:0] cmd_wr_ptr_r;
   logic [CW-1:0] cmd_rd_ptr_r;
   logic [CW:0]   cmd_count_r;
   logic [CW:0]   cmd_count_nxt_s;
   logic          cmd_valid_r;

   logic [32:0]   res_mem_r [RES_DEPTH];
   logic [RW-1:0] res_wr_ptr_r;
   logic [RW-1:0] res_rd_ptr_r;
   logic [RW:0]   res_count_r;
   logic [RW:0]   res_count_nxt_s;
   logic          res_ready_r;

   logic [34:0]   tx_shift_r;
   logic          tx_present_r;
   logic          tx_ovf_r;
   logic          overflow_r;
   logic          overflow_nxt_s;

   logic          frame_done_s;
   logic          cmd_full_s;
   logic          cmd_pop_s;
   logic          cmd_push_s;
   logic          drop_s;
   logic [65:0]   frame_word_s;
   logic [65:0]   cmd_head_s;
   logic          res_empty_s;
   logic          res_push_s;
   logic          res_pop_s;
   logic [32:0]   res_head_s;
   logic          commit_s;
   logic          tx_load_s;
   logic [34:0]   response_s;

   assign frame_done_s = ~cs_n & (bit_cnt_r == LAST_BIT);
   assign frame_word_s = {rx_shift_r, mosi};
   assign cmd_full_s   = (cmd_count_r == CMD_FULL);
   assign cmd_pop_s    = cmd_valid_r & cmd_ready;
   // A pop on the completion edge frees the slot the new frame needs.
   assign cmd_push_s   = frame_done_s & (~cmd_full_s | cmd_pop_s);
   assign drop_s       = frame_done_s & cmd_full_s & ~cmd_pop_s;
   assign cmd_head_s   = cmd_mem_r[cmd_rd_ptr_r];

   assign res_empty_s  = (res_count_r == (RW+1)'(0));
   assign res_push_s   = res_valid & res_ready_r;
   assign res_head_s   = res_empty_s ? 33'd0 : res_mem_r[res_rd_ptr_r];
   assign commit_s     = ~cs_n & (bit_cnt_r == RESP_LAST);
   assign res_pop_s    = commit_s & tx_present_r;
   assign tx_load_s    = cs_n | (bit_cnt_r == LAST_BIT);
   assign response_s   = {~res_empty_s, overflow_r, res_head_s};

   assign miso      = tx_shift_r[34];
   assign cmd_valid = cmd_valid_r;
   assign cmd_op    = cmd_head_s[65:64];
   assign cmd_a     = cmd_head_s[63:32];
   assign cmd_b     = cmd_head_s[31:0];
   assign res_ready = res_ready_r;
   assign cmd_count = cmd_count_r;
   assign overflow  = overflow_r;

   // Occupancy and sticky-overflow next-state
   always_comb begin
      cmd_count_nxt_s = cmd_count_r;
      res_count_nxt_s = res_count_r;
      overflow_nxt_s  = overflow_r;
      case ({cmd_push_s, cmd_pop_s})
         2'b10:   cmd_count_nxt_s = cmd_count_r + (CW+1)'(1);
         2'b01:   cmd_count_nxt_s = cmd_count_r - (CW+1)'(1);
         default: cmd_count_nxt_s = cmd_count_r;
      endcase
      case ({res_push_s, res_pop_s})
         2'b10:   res_count_nxt_s = res_count_r + (RW+1)'(1);
         2'b01:   res_count_nxt_s = res_count_r - (RW+1)'(1);
         default: res_count_nxt_s = res_count_r;
      endcase
      // A fresh drop outranks the clear from a delivered ovf bit.
      if (drop_s) begin
         overflow_nxt_s = 1'b1;
      end else if (commit_s && tx_ovf_r) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end
   end

   // Frame deserializer and bit counter
   always_ff @(posedge SCLK or posedge rst) begin
      if (rst) begin
         bit_cnt_r  <= 7'd0;
         rx_shift_r <= 65'd0;
      end else if (cs_n) begin
         bit_cnt_r  <= 7'd0;
      end else begin
         rx_shift_r <= {rx_shift_r[63:0], mosi};
         bit_cnt_r  <= (bit_cnt_r == LAST_BIT) ? 7'd0 : bit_cnt_r + 7'd1;
      end
   end

   // Command FIFO
   always_ff @(posedge SCLK or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CMD_DEPTH; i++) cmd_mem_r[i] <= 66'd0;
         cmd_wr_ptr_r <= CW'(0);
         cmd_rd_ptr_r <= CW'(0);
         cmd_count_r  <= (CW+1)'(0);
         cmd_valid_r  <= 1'b0;
      end else begin
         if (cmd_push_s) begin
            cmd_mem_r[cmd_wr_ptr_r] <= frame_word_s;
            cmd_wr_ptr_r            <= cmd_wr_ptr_r + CW'(1);
         end
         if (cmd_pop_s) cmd_rd_ptr_r <= cmd_rd_ptr_r + CW'(1);
         cmd_count_r <= cmd_count_nxt_s;
         cmd_valid_r <= (cmd_count_nxt_s != (CW+1)'(0));
      end
   end

   // Result FIFO
   always_ff @(posedge SCLK or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RES_DEPTH; i++) res_mem_r[i] <= 33'd0;
         res_wr_ptr_r <= RW'(0);
         res_rd_ptr_r <= RW'(0);
         res_count_r  <= (RW+1)'(0);
         res_ready_r  <= 1'b1;
      end else begin
         if (res_push_s) begin
            res_mem_r[res_wr_ptr_r] <= {res_err, res_data};
            res_wr_ptr_r            <= res_wr_ptr_r + RW'(1);
         end
         if (res_pop_s) res_rd_ptr_r <= res_rd_ptr_r + RW'(1);
         res_count_r <= res_count_nxt_s;
         res_ready_r <= (res_count_nxt_s != RES_FULL);
      end
   end

   // Response shifter; remembers the loaded present/ovf bits for the commit edge
   always_ff @(posedge SCLK or posedge rst) begin
      if (rst) begin
         tx_shift_r   <= 35'd0;
         tx_present_r <= 1'b0;
         tx_ovf_r     <= 1'b0;
         overflow_r   <= 1'b0;
      end else begin
         overflow_r <= overflow_nxt_s;
         if (tx_load_s) begin
            tx_shift_r   <= response_s;
            tx_present_r <= response_s[34];
            tx_ovf_r     <= response_s[33];
         end else if (bit_cnt_r < RESP_LEN) begin
            tx_shift_r   <= {tx_shift_r[33:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_fpu_spi_sched.sv
// Randomized self-checking bench for fpu_spi_sched against a queue-based
// model of the frame, FIFO and response rules, plus directed literal checks.
module tb_fpu_spi_sched;
   localparam int CMD_DEPTH = 4;
   localparam int RES_DEPTH = 2;

   logic        SCLK = 1'b0;
   logic        rst  = 1'b1;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic        cmd_valid;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        cmd_ready = 1'b0;
   logic        res_valid = 1'b0;
   logic [31:0] res_data  = 32'd0;
   logic        res_err   = 1'b0;
   logic        res_ready;
   logic [2:0]  cmd_count;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   fpu_spi_sched #(.CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
      .SCLK(SCLK), .rst(rst), .cs_n(cs_n), .mosi(mosi), .miso(miso),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_ready(cmd_ready), .res_valid(res_valid), .res_data(res_data),
      .res_err(res_err), .res_ready(res_ready), .cmd_count(cmd_count),
      .overflow(overflow)
   );

   always #5 SCLK = ~SCLK;

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [65:0] m_cmdq[$];
   logic [32:0] m_resq[$];
   int          m_bits = 0;
   logic [64:0] m_rx   = 65'd0;
   logic        m_ovf  = 1'b0;
   logic [34:0] m_resp = 35'd0;   // response word of the current frame
   int          m_idx  = 0;       // how many response bits have been sent

   task automatic model_step();
      logic [34:0] new_resp;
      logic        pop_c, push_r, done, commit, load, drop;
      int          csize;
      csize   = m_cmdq.size();
      pop_c   = (csize > 0) && cmd_ready;
      push_r  = res_valid && (m_resq.size() < RES_DEPTH);
      done    = !cs_n && (m_bits == 65);
      commit  = !cs_n && (m_bits == 34);
      load    = cs_n || (m_bits == 65);
      new_resp = (m_resq.size() > 0) ? {1'b1, m_ovf, m_resq[0]} : {1'b0, m_ovf, 33'd0};
      drop    = 1'b0;
      if (commit && m_resp[34]) void'(m_resq.pop_front());
      if (commit && m_resp[33]) m_ovf = 1'b0;
      if (push_r) m_resq.push_back({res_err, res_data});
      if (pop_c) void'(m_cmdq.pop_front());
      if (done) begin
         if (csize < CMD_DEPTH || pop_c) m_cmdq.push_back({m_rx, mosi});
         else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      if (load) begin
         m_resp = new_resp;
         m_idx  = 0;
      end else if (m_bits < 35) begin
         m_idx++;
      end
      if (!cs_n) m_rx = {m_rx[63:0], mosi};
      m_bits = cs_n ? 0 : ((m_bits == 65) ? 0 : m_bits + 1);
   endtask

   function automatic logic exp_miso();
      if (m_idx < 35) return m_resp[34 - m_idx];
      return 1'b0;
   endfunction

   initial forever begin
      @(posedge SCLK or posedge rst);
      if (rst) begin
         m_cmdq.delete();
         m_resq.delete();
         m_bits = 0;
         m_ovf  = 1'b0;
         m_resp = 35'd0;
         m_idx  = 0;
      end else begin
         model_step();
      end
   end

   // Per-cycle comparison against the model, mid-cycle
   initial forever begin
      @(negedge SCLK);
      if (!rst) begin
         check("miso", 66'(miso), 66'(exp_miso()));
         check("cmd_valid", 66'(cmd_valid), 66'(m_cmdq.size() > 0));
         check("cmd_count", 66'(cmd_count), 66'(m_cmdq.size()));
         check("res_ready", 66'(res_ready), 66'(m_resq.size() < RES_DEPTH));
         check("overflow", 66'(overflow), 66'(m_ovf));
         if (m_cmdq.size() > 0) check("cmd_head", {cmd_op, cmd_a, cmd_b}, m_cmdq[0]);
      end
   end

   // ---------------- stimulus ----------------
   logic [65:0] cap = 66'd0;      // miso seen before each bit edge, cap[65] first
   logic        ovf_after34 = 1'b0;
   bit          rand_core = 1'b0;

   initial forever begin
      @(posedge SCLK);
      #2;
      if (rand_core) begin
         cmd_ready = ($urandom_range(0, 3) == 0);
         res_valid = ($urandom_range(0, 2) == 0);
         res_data  = $urandom;
         res_err   = 1'($urandom_range(0, 1));
      end
   end

   task automatic do_reset();
      cs_n = 1'b1;
      mosi = 1'b0;
      rst  = 1'b1;
      @(posedge SCLK);
      #2;
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      cs_n = 1'b1;
      mosi = 1'b0;
      repeat (n) begin
         @(posedge SCLK);
         #2;
      end
   endtask

   task automatic push_result(input logic [31:0] d, input logic e);
      res_valid = 1'b1;
      res_data  = d;
      res_err   = e;
      @(posedge SCLK);
      #2;
      res_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int nbits, input bit ready_last);
      logic [65:0] w;
      w = {op, a, b};
      for (int i = 0; i < nbits; i++) begin
         cs_n = 1'b0;
         mosi = w[65 - i];
         if (ready_last && i == 65) cmd_ready = 1'b1;
         @(negedge SCLK);
         cap[65 - i] = miso;
         @(posedge SCLK);
         #2;
         if (i == 34) ovf_after34 = overflow;
      end
      if (ready_last) cmd_ready = 1'b0;
      if (nbits < 66) begin
         cs_n = 1'b1;
         mosi = 1'b0;
      end
   endtask

   initial begin
      logic [34:0] exp_resp;
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [34:0] exp_resp;
      do_reset();
      check("rst_cmd_valid", 66'(cmd_valid), 66'd0);
      check("rst_cmd_count", 66'(cmd_count), 66'd0);
      check("rst_res_ready", 66'(res_ready), 66'd1);
      check("rst_miso", 66'(miso), 66'd0);
      check("rst_overflow", 66'(overflow), 66'd0);

      // single mul frame appears on cmd_* one edge after bit 65
      send_frame(2'b10, 32'h40000000, 32'h40400000, 66, 1'b0);
      check("t1_valid", 66'(cmd_valid), 66'd1);
      check("t1_op", 66'(cmd_op), 66'd2);
      check("t1_a", 66'(cmd_a), 66'h40000000);
      check("t1_b", 66'(cmd_b), 66'h40400000);
      check("t1_count", 66'(cmd_count), 66'd1);
      idle(1);

      // five back-to-back frames into a 4-deep queue
      do_reset();
      cmd_ready = 1'b0;
      for (int k = 0; k < 5; k++)
         send_frame(2'(k), 32'h1000 + 32'(k), 32'hABCD0000 + 32'(k), 66, 1'b0);
      check("t2_count", 66'(cmd_count), 66'd4);
      check("t2_overflow", 66'(overflow), 66'd1);
      check("t2_head_a", 66'(cmd_a), 66'h1000);
      idle(1);
      send_frame(2'b01, 32'h1, 32'h2, 66, 1'b0);
      check("t2_resp_hdr", 66'(cap[65:63]), 66'b010);
      check("t2_ovf_cleared", 66'(ovf_after34), 66'd0);

      // result delivered MSB first, then popped
      do_reset();
      cmd_ready = 1'b1;
      push_result(32'h40C00000, 1'b0);
      idle(1);
      send_frame(2'b00, 32'h3, 32'h4, 66, 1'b0);
      exp_resp = {1'b1, 1'b0, 1'b0, 32'h40C00000};
      check("t3_resp", 66'(cap[65:31]), 66'(exp_resp));
      send_frame(2'b00, 32'h5, 32'h6, 66, 1'b0);
      check("t3_present_after_pop", 66'(cap[65]), 66'd0);
      idle(1);

      // aborted frame: no push, no pop, identical resend
      cmd_ready = 1'b0;
      push_result(32'h3F800000, 1'b1);
      idle(1);
      exp_resp = {1'b1, 1'b0, 1'b1, 32'h3F800000};
      send_frame(2'b11, 32'h7, 32'h8, 20, 1'b0);
      check("t4_partial", 66'(cap[65:46]), 66'(exp_resp[34:15]));
      idle(1);
      check("t4_no_push", 66'(cmd_count), 66'd0);
      send_frame(2'b11, 32'h7, 32'h8, 66, 1'b0);
      check("t4_resend", 66'(cap[65:31]), 66'(exp_resp));
      check("t4_count", 66'(cmd_count), 66'd1);
      idle(1);

      // full queue with a pop on the completion edge
      do_reset();
      cmd_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         send_frame(2'b01, 32'h2000 + 32'(k), 32'h0, 66, 1'b0);
      send_frame(2'b10, 32'hCAFE0000, 32'h12345678, 66, 1'b1);
      check("t5_count", 66'(cmd_count), 66'd4);
      check("t5_overflow", 66'(overflow), 66'd0);
      check("t5_head_a", 66'(cmd_a), 66'h2001);
      idle(1);

      // asynchronous reset mid-frame
      do_reset();
      cmd_ready = 1'b0;
      send_frame(2'b00, 32'h11, 32'h22, 66, 1'b0);
      send_frame(2'b01, 32'h33, 32'h44, 66, 1'b0);
      idle(1);
      push_result(32'hFFFFFFFF, 1'b0);
      idle(1);
      send_frame(2'b00, 32'h0, 32'h0, 10, 1'b0);
      #1 rst = 1'b1;
      #1;
      check("t6_cmd_valid", 66'(cmd_valid), 66'd0);
      check("t6_cmd_count", 66'(cmd_count), 66'd0);
      check("t6_res_ready", 66'(res_ready), 66'd1);
      check("t6_miso", 66'(miso), 66'd0);
      @(posedge SCLK);
      #2 rst = 1'b0;
      idle(1);

      // randomized traffic, checked every cycle by the model
      rand_core = 1'b1;
      for (int f = 0; f < 45; f++) begin
         int nb;
         nb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 65)) : 66;
         send_frame(2'($urandom_range(0, 3)), $urandom, $urandom, nb, 1'b0);
         if (nb < 66 || $urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
      end
      rand_core = 1'b0;
      idle(2);
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
